mirfak_muldiv: RTL and testbench

Iterative RV32M multiply/divide responder for the execute stage. It complements the single-cycle ALU. The pipeline issues a request with operands and funct3. The unit computes over multiple cycles and returns a held result that the pipeline must acknowledge. A kill input aborts in-flight work on flush or exception.

---
 rtl/mirfak_muldiv.sv | 162 ++++++++++++++++
 tb/tb_mirfak_muldiv.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mirfak_muldiv.sv
// mirfak_muldiv: iterative RV32M multiply/divide unit with a request/result
// handshake. Multiply is radix-2 shift-add; divide is restoring division.
// Division by zero and signed overflow are resolved at the accept edge.
module mirfak_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic [2:0]      op_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            kill_i,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  input  logic            result_ack_i
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   ma_q, ma_d, mb_q, mb_d;
  // hi: upper product word / partial remainder; lo: multiplier / quotient
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              sa_in, sb_in;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     add, shl, diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   val;

  assign req_ready_o    = (state_q == IDLE);
  assign result_valid_o = (state_q == DONE);
  assign result_o       = res_q;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
    end
  end

  // Next-state, iteration step and sign correction
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;

    sa_in = operand_a_i[XLEN-1] &
            (op_i == OP_MULH || op_i == OP_MULHSU || op_i == OP_DIV || op_i == OP_REM);
    sb_in = operand_b_i[XLEN-1] &
            (op_i == OP_MULH || op_i == OP_DIV || op_i == OP_REM);
    abs_a = sa_in ? -operand_a_i : operand_a_i;
    abs_b = sb_in ? -operand_b_i : operand_b_i;

    add  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, ma_q} : '0);
    shl  = {hi_q, lo_q[XLEN-1]};
    diff = shl - {1'b0, mb_q};

    prod = {hi_q, lo_q};
    if (sa_q ^ sb_q) prod = -prod;
    val  = lo_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i && !kill_i) begin
          op_d  = op_i;
          sa_d  = sa_in;
          sb_d  = sb_in;
          ma_d  = abs_a;
          mb_d  = abs_b;
          cnt_d = '0;
          hi_d  = '0;
          lo_d  = op_i[2] ? abs_a : abs_b;
          if (op_i[2] && operand_b_i == '0) begin
            res_d   = op_i[1] ? operand_a_i : '1;
            state_d = DONE;
          end else if (op_i[2] && !op_i[0] && operand_a_i == {1'b1, {(XLEN-1){1'b0}}} &&
                       operand_b_i == '1) begin
            res_d   = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (op_q[2]) begin
          if (!diff[XLEN]) begin
            hi_d = diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = shl[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = add[XLEN:1];
          lo_d = {add[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        if (!op_q[2]) begin
          res_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else if (op_q[1]) begin
          // remainder follows the dividend sign only
          val   = hi_q;
          res_d = sa_q ? -val : val;
        end else begin
          res_d = (sa_q ^ sb_q) ? -val : val;
        end
        state_d = DONE;
      end
      DONE: begin
        if (result_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (kill_i) state_d = IDLE;
  end

endmodule

// File: tb/tb_mirfak_muldiv.sv
// Directed self-checking bench for mirfak_muldiv.
module tb_mirfak_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        req_valid, req_ready, kill, res_valid, ack;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mirfak_muldiv #(.XLEN(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .operand_a_i    (a),
    .operand_b_i    (b),
    .op_i           (op),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .kill_i         (kill),
    .result_o       (result),
    .result_valid_o (res_valid),
    .result_ack_i   (ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller sits #1 after a rising edge with the unit idle. exp_cyc is the
  // number of cycles from the accept cycle to the first cycle with valid high.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [31:0] exp, input int exp_cyc);
    int k;
    op = o; a = ia; b = ib; req_valid = 1'b1;
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
    k = 0;
    while (!res_valid && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_lat"}, k + 1, exp_cyc);
    check({tag, "_res"}, result, exp);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check({tag, "_idle"}, {30'd0, req_ready, res_valid}, 32'b10);
  endtask

  initial begin
    int seen;
    int k;
    rst_n = 1'b0; a = '0; b = '0; op = '0; req_valid = 1'b0; kill = 1'b0; ack = 1'b0;
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, res_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_m1",    3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34);
    run_op("mulh_m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34);
    run_op("mulhu_m1",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op("mulhsu_m1", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    run_op("mul_7m3",   3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op("div_m7_2",  3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    run_op("rem_m7_2",  3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    run_op("divu_100",  3'b101, 32'd100,      32'd7,        32'd14,       34);
    run_op("remu_100",  3'b111, 32'd100,      32'd7,        32'd2,        34);
    run_op("divu_z",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("remu_z",    3'b111, 32'd5,        32'd0,        32'h00000005, 1);
    run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run_op("div_7_m2",  3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34);

    // kill during CALC
    op = 3'b011; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_calc", {30'd0, req_ready, res_valid}, 32'b10);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1;
    end
    check("kill_novalid", seen, 0);

    // kill together with a request in IDLE: fast-path op would show valid
    op = 3'b101; a = 32'd5; b = 32'd0; req_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; kill = 1'b0;
    check("kill_req", {30'd0, req_ready, res_valid}, 32'b10);

    // kill in DONE discards the result
    op = 3'b101; a = 32'd5; b = 32'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("kd_valid", {31'd0, res_valid}, 32'd1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kd_idle", {30'd0, req_ready, res_valid}, 32'b10);

    // result held without ack; requests in DONE are refused
    op = 3'b101; a = 32'd100; b = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (!res_valid && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check("hold_lat", k + 1, 34);
    op = 3'b111; a = 32'd9; b = 32'd0; req_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_res", result, 32'd14);
      check("hold_flags", {30'd0, req_ready, res_valid}, 32'b01);
    end
    req_valid = 1'b0; ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check("hold_ack", {30'd0, req_ready, res_valid}, 32'b10);

    // reset mid-CALC
    op = 3'b001; a = 32'h12345678; b = 32'h9ABCDEF0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {30'd0, req_ready, res_valid}, 32'b10);
    check("mid_rst_result", result, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1;
    end
    check("rst_novalid", seen, 0);
    run_op("post_rst", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
